vending_core_param: RTL
=======================

Name: vending_core_param

Overview:
- Parametrised successor to the vending machine top. Owns the vending datapath for NUM_PRODUCTS product slots: per-slot stock and price, customer credit, machine cash box, and a circular purchase log.
- Commands arrive with the existing mode encoding (0..7) plus a refund mode, over a valid/ready handshake. Each command returns a status and data response.
- Sits between the front-panel input/decoder and the 7-segment display driver. The display driver consumes resp_data, customerMoney and machineMoney.

Parameters:
- NUM_PRODUCTS, 8: number of product slots, 2..2**CODE_W.
- CODE_W, 3: productCode width.
- COUNT_W, 4: productCount and stock width.
- MONEY_W, 8: width of price, credit, cash and amount.
- STOCK_MAX, 15: per-slot stock ceiling, at most 2**COUNT_W-1.
- DEFAULT_PRICE, 5: price loaded into every slot at reset.
- LOG_DEPTH, 8: number of purchase log entries, power of two, at least 2.

Ports:
- mainClock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- mode  in  4  command opcode.
- productCode  in  CODE_W  slot index.
- productCount  in  COUNT_W  buy or restock quantity.
- amount  in  MONEY_W  withdraw, new-price or credit amount.
- resp_valid  out  1  one-cycle response strobe.
- resp_status  out  3  0 OK, 1 ERR_STOCK, 2 ERR_FUNDS, 3 ERR_CODE, 4 ERR_OVF, 5 ERR_MODE.
- resp_data  out  MONEY_W  response payload.
- customerMoney  out  MONEY_W  current customer credit.
- machineMoney  out  MONEY_W  current cash box.
- log_rd_en  in  1  pop the oldest log entry.
- log_entry  out  CODE_W+COUNT_W+MONEY_W  oldest entry, packed {code, count, cost}; valid when log_empty=0.
- log_empty  out  1  log holds no entries.
- log_count  out  clog2(LOG_DEPTH)+1  number of entries held.
- log_overflow  out  1  sticky flag: an entry was overwritten.

Behaviour:
- Reset (synchronous, at the edge with reset=1):
  - All stock 0; all prices DEFAULT_PRICE; customerMoney 0; machineMoney 0.
  - FSM to IDLE; cmd_ready 1; resp_valid 0; resp_status 0; resp_data 0.
  - Log emptied: log_count 0, log_empty 1, log_overflow 0.
  - Reset overrides everything, including a command in flight: no response is issued for it.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch mode, productCode, productCount and amount, then go to EXEC.
  - EXEC: cmd_ready=0. Evaluate the command and update state, then go to RESP.
  - RESP: cmd_ready=0, resp_valid=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Command accepted at edge N gives resp_valid high in the cycle after edge N+2.
  - Maximum throughput is one command per 3 cycles.
  - Inputs are ignored while cmd_ready=0.
- Check order (first failing check sets the status; on any error no state changes):
  1. Mode above 8 gives ERR_MODE.
  2. For modes 0, 1, 3 and 4, productCode >= NUM_PRODUCTS gives ERR_CODE.
  3. Mode-specific checks, listed below.
- Cost arithmetic:
  - cost = price[code] * productCount, computed at full MONEY_W+COUNT_W width with no truncation.
  - The comparison against customerMoney uses zero extension.
- Mode 0, buy:
  - productCount 0 returns OK with no change and no log entry.
  - stock < count gives ERR_STOCK.
  - cost > customerMoney gives ERR_FUNDS.
  - machineMoney + cost > 2**MONEY_W-1 gives ERR_OVF.
  - On success: stock -= count, customerMoney -= cost, machineMoney += cost, resp_data = cost (fits because cost <= customerMoney), and the entry is pushed to the log.
- Mode 1, restock: stock + count > STOCK_MAX gives ERR_OVF. Otherwise stock += count and resp_data = new stock.
- Mode 2, owner withdraw: amount > machineMoney gives ERR_FUNDS. Otherwise machineMoney -= amount and resp_data = amount.
- Mode 3, query: resp_data = stock[code], zero-extended.
- Mode 4, set price: price[code] = amount and resp_data = amount. A price of 0 is legal.
- Mode 5: resp_data = customerMoney.
- Mode 6: resp_data = machineMoney.
- Mode 7, credit: customerMoney + amount overflow gives ERR_OVF. Otherwise customerMoney += amount and resp_data = new credit.
- Mode 8, refund: resp_data = customerMoney, then customerMoney = 0.
- resp_data on error: 0.
- resp_status and resp_data: hold their values until the next RESP.
- Log (circular buffer; independent of the FSM):
  - Push happens only on a successful buy with count > 0, on the EXEC edge.
  - A push when full overwrites the oldest entry, advances the read pointer, keeps log_count = LOG_DEPTH, and sets log_overflow.
  - log_rd_en with log_empty=0 pops one entry per edge. log_rd_en when empty is ignored.
  - log_entry is combinational from the read pointer.
  - Push and pop on the same edge:
    - Not empty, not full: both happen and log_count is unchanged.
    - Empty: the push only.
    - Full: the oldest entry is popped, the new entry is written, log_count is unchanged, and log_overflow is not set.
- Pointers: wrap modulo LOG_DEPTH.

Test Plan:
1. Reset; mode 7 amount 20; mode 1 code 4 count 7; mode 0 code 4 count 3 -> status 0 and resp_data 15; customerMoney 5, machineMoney 15; mode 3 code 4 returns 4; log_entry {4,3,15}, log_count 1. Each response arrives 2 cycles after acceptance, with cmd_ready low for 2 cycles.
2. From state 1: mode 0 code 4 count 2 (cost 10 > 5) -> ERR_FUNDS, resp_data 0, credit, stock and log unchanged. Then mode 1 code 4 count 12 -> ERR_OVF (4+12 > 15). Then mode 2 amount 10 -> OK, resp_data 10, machineMoney 5.
3. Set NUM_PRODUCTS=6: mode 0 code 7 -> ERR_CODE. Mode 12 -> ERR_MODE. Mode 4 code 2 amount 15, then buy code 2 count 1 with credit 20 -> cost 15, credit 5.
4. Log wrap with LOG_DEPTH=8: nine successful buys of count 1 on codes 0..8 mod 8 -> log_count 8 and log_overflow 1. The first pop returns the second buy (code 1); eight pops leave log_empty 1, and a further pop leaves log_count at 0.
5. Simultaneous push/pop with a full log: log_rd_en asserted on the EXEC edge of a buy -> log_count stays 8, log_overflow unchanged, and the newest entry is at the tail.
6. Reset asserted during EXEC of a buy -> resp_valid never rises; next cycle cmd_ready 1, customerMoney 0, all prices 5, log_empty 1. Then mode 8 after a 9-unit credit -> resp_data 9, customerMoney 0.

Source files
------------

// File: rtl/vending_core_param.sv
// Parametrised vending datapath: slot stock/price, credit, cash box and a
// circular purchase log, driven by a three-state IDLE/EXEC/RESP command FSM.
module vending_core_param #(
  parameter int NUM_PRODUCTS  = 8,
  parameter int CODE_W        = 3,
  parameter int COUNT_W       = 4,
  parameter int MONEY_W       = 8,
  parameter int STOCK_MAX     = 15,
  parameter int DEFAULT_PRICE = 5,
  parameter int LOG_DEPTH     = 8
) (
  input  logic                                 mainClock,
  input  logic                                 reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [3:0]                           mode,
  input  logic [CODE_W-1:0]                    productCode,
  input  logic [COUNT_W-1:0]                   productCount,
  input  logic [MONEY_W-1:0]                   amount,
  output logic                                 resp_valid,
  output logic [2:0]                           resp_status,
  output logic [MONEY_W-1:0]                   resp_data,
  output logic [MONEY_W-1:0]                   customerMoney,
  output logic [MONEY_W-1:0]                   machineMoney,
  input  logic                                 log_rd_en,
  output logic [CODE_W+COUNT_W+MONEY_W-1:0]    log_entry,
  output logic                                 log_empty,
  output logic [$clog2(LOG_DEPTH):0]           log_count,
  output logic                                 log_overflow
);
  localparam int PTR_W   = $clog2(LOG_DEPTH);
  localparam int ENTRY_W = CODE_W + COUNT_W + MONEY_W;
  localparam int COST_W  = MONEY_W + COUNT_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_STOCK = 3'd1;
  localparam logic [2:0] ST_FUNDS = 3'd2;
  localparam logic [2:0] ST_CODE  = 3'd3;
  localparam logic [2:0] ST_OVF   = 3'd4;
  localparam logic [2:0] ST_MODE  = 3'd5;

  logic [1:0]         r_state;
  logic [3:0]         r_mode;
  logic [CODE_W-1:0]  r_code;
  logic [COUNT_W-1:0] r_count;
  logic [MONEY_W-1:0] r_amount;
  logic [COUNT_W-1:0] r_stock [NUM_PRODUCTS];
  logic [MONEY_W-1:0] r_price [NUM_PRODUCTS];
  logic [MONEY_W-1:0] r_cust;
  logic [MONEY_W-1:0] r_mach;
  logic [2:0]         r_pend_status;
  logic [MONEY_W-1:0] r_pend_data;
  logic               r_resp_valid;
  logic [2:0]         r_resp_status;
  logic [MONEY_W-1:0] r_resp_data;

  logic [ENTRY_W-1:0] r_log_mem [LOG_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_log_count;
  logic               r_log_ovf;

  logic [COUNT_W-1:0] w_stock;
  logic [MONEY_W-1:0] w_price;
  logic [COST_W-1:0]  w_cost;
  logic [COST_W:0]    w_mach_sum;
  logic [COUNT_W:0]   w_stock_sum;
  logic [MONEY_W:0]   w_credit_sum;
  logic               w_code_bad;
  logic [2:0]         w_status;
  logic [MONEY_W-1:0] w_data;
  logic               w_do_buy, w_do_restock, w_do_withdraw;
  logic               w_do_price, w_do_credit, w_do_refund;
  logic               w_push, w_pop, w_full;
  logic [ENTRY_W-1:0] w_push_entry;

  // Slot read through an explicit mux so codes beyond NUM_PRODUCTS read as 0.
  always_comb begin
    w_stock = '0;
    w_price = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (r_code == CODE_W'(i)) begin
        w_stock = r_stock[i];
        w_price = r_price[i];
      end
    end
  end

  assign w_cost       = COST_W'(w_price) * COST_W'(r_count);
  assign w_mach_sum   = (COST_W+1)'(r_mach) + (COST_W+1)'(w_cost);
  assign w_stock_sum  = {1'b0, w_stock} + {1'b0, r_count};
  assign w_credit_sum = {1'b0, r_cust} + {1'b0, r_amount};
  assign w_code_bad   = (int'(r_code) >= NUM_PRODUCTS);
  assign w_push_entry = {r_code, r_count, w_cost[MONEY_W-1:0]};

  always_comb begin
    w_status      = ST_OK;
    w_data        = '0;
    w_do_buy      = 1'b0;
    w_do_restock  = 1'b0;
    w_do_withdraw = 1'b0;
    w_do_price    = 1'b0;
    w_do_credit   = 1'b0;
    w_do_refund   = 1'b0;
    if (r_mode > 4'd8) begin
      w_status = ST_MODE;
    end else if ((r_mode == 4'd0 || r_mode == 4'd1 || r_mode == 4'd3 || r_mode == 4'd4) && w_code_bad) begin
      w_status = ST_CODE;
    end else begin
      case (r_mode)
        4'd0: begin
          if (r_count == '0) begin
            w_status = ST_OK;
          end else if (w_stock < r_count) begin
            w_status = ST_STOCK;
          end else if (w_cost > COST_W'(r_cust)) begin
            w_status = ST_FUNDS;
          end else if (w_mach_sum[COST_W:MONEY_W] != '0) begin
            w_status = ST_OVF;
          end else begin
            w_do_buy = 1'b1;
            w_data   = w_cost[MONEY_W-1:0];
          end
        end
        4'd1: begin
          if (w_stock_sum > (COUNT_W+1)'(STOCK_MAX)) begin
            w_status = ST_OVF;
          end else begin
            w_do_restock = 1'b1;
            w_data       = MONEY_W'(w_stock_sum[COUNT_W-1:0]);
          end
        end
        4'd2: begin
          if (r_amount > r_mach) begin
            w_status = ST_FUNDS;
          end else begin
            w_do_withdraw = 1'b1;
            w_data        = r_amount;
          end
        end
        4'd3: w_data = MONEY_W'(w_stock);
        4'd4: begin
          w_do_price = 1'b1;
          w_data     = r_amount;
        end
        4'd5: w_data = r_cust;
        4'd6: w_data = r_mach;
        4'd7: begin
          if (w_credit_sum[MONEY_W]) begin
            w_status = ST_OVF;
          end else begin
            w_do_credit = 1'b1;
            w_data      = w_credit_sum[MONEY_W-1:0];
          end
        end
        4'd8: begin
          w_do_refund = 1'b1;
          w_data      = r_cust;
        end
        default: w_status = ST_MODE;
      endcase
    end
  end

  // Response registers update on the RESP edge so resp_valid rises two edges after acceptance.
  always_ff @(posedge mainClock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mode        <= '0;
      r_code        <= '0;
      r_count       <= '0;
      r_amount      <= '0;
      r_cust        <= '0;
      r_mach        <= '0;
      r_pend_status <= ST_OK;
      r_pend_data   <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_status <= ST_OK;
      r_resp_data   <= '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        r_stock[i] <= '0;
        r_price[i] <= MONEY_W'(DEFAULT_PRICE);
      end
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_mode   <= mode;
            r_code   <= productCode;
            r_count  <= productCount;
            r_amount <= amount;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_pend_status <= w_status;
          r_pend_data   <= w_data;
          for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (r_code == CODE_W'(i)) begin
              if (w_do_buy)     r_stock[i] <= w_stock - r_count;
              if (w_do_restock) r_stock[i] <= w_stock_sum[COUNT_W-1:0];
              if (w_do_price)   r_price[i] <= r_amount;
            end
          end
          if (w_do_buy)      r_cust <= r_cust - w_cost[MONEY_W-1:0];
          if (w_do_credit)   r_cust <= w_credit_sum[MONEY_W-1:0];
          if (w_do_refund)   r_cust <= '0;
          if (w_do_buy)      r_mach <= w_mach_sum[MONEY_W-1:0];
          if (w_do_withdraw) r_mach <= r_mach - r_amount;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid  <= 1'b1;
          r_resp_status <= r_pend_status;
          r_resp_data   <= r_pend_data;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push = (r_state == S_EXEC) && w_do_buy;
  assign w_pop  = log_rd_en && (r_log_count != '0);
  assign w_full = (r_log_count == (PTR_W+1)'(LOG_DEPTH));

  always_ff @(posedge mainClock) begin
    if (w_push) r_log_mem[r_wr_ptr] <= w_push_entry;
  end

  // A push into a full log drops the oldest entry; only a push without a pop flags overflow.
  always_ff @(posedge mainClock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_log_count <= '0;
      r_log_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_push && w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else if (w_push) begin
        if (w_full) begin
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
          r_log_ovf <= 1'b1;
        end else begin
          r_log_count <= r_log_count + 1'b1;
        end
      end else if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_log_count <= r_log_count - 1'b1;
      end
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_status   = r_resp_status;
  assign resp_data     = r_resp_data;
  assign customerMoney = r_cust;
  assign machineMoney  = r_mach;
  assign log_entry     = r_log_mem[r_rd_ptr];
  assign log_empty     = (r_log_count == '0);
  assign log_count     = r_log_count;
  assign log_overflow  = r_log_ovf;
endmodule
